tile_renderer: RTL and testbench

TILE_RENDERER -- requirements
Module: tile_renderer

---
 rtl/tile_renderer_pkg.sv | 32 +++
 rtl/infra/defs.vh | 15 +
 rtl/tile_renderer_blink_timer.sv | 50 +++++
 rtl/tile_renderer.sv | 143 ++++++++++++++
 tb/tb_tile_renderer.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/tile_renderer_pkg.sv
// Shared types for the tile renderer: coordinate widths and palette selection.
`include "infra/defs.vh"

package tile_renderer_pkg;

   localparam int GX_W = 8;
   localparam int GY_W = 7;

   typedef enum logic [2:0] {
      PAL_BLK,
      PAL_BG,
      PAL_EDGE,
      PAL_HEAD,
      PAL_APPLE,
      PAL_BODY
   } pal_sel_t;

   function automatic logic [2:0] pal_rgb(input pal_sel_t sel);
      logic [2:0] c;
      c = `COL_BLK;
      case (sel)
         PAL_BG:    c = `COL_BG;
         PAL_EDGE:  c = `COL_EDGE;
         PAL_HEAD:  c = `COL_HEAD;
         PAL_APPLE: c = `COL_APPLE;
         PAL_BODY:  c = `COL_BODY;
         default:   c = `COL_BLK;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/infra/defs.vh
// Shared grid geometry and 3-bit {R,G,B} palette for the tile renderer.
`ifndef TILE_RENDERER_DEFS_VH
`define TILE_RENDERER_DEFS_VH

`define GRID_COLS 160
`define GRID_ROWS 120

`define COL_BLK   3'b000
`define COL_BG    3'b001
`define COL_EDGE  3'b111
`define COL_HEAD  3'b110
`define COL_APPLE 3'b100
`define COL_BODY  3'b010

`endif

// File: rtl/tile_renderer_blink_timer.sv
// Game-over blink timer: counts frames while game_over is high and toggles the
// snake visibility phase every BLINK_FRAMES frames.
module blink_timer #(
   parameter int BLINK_FRAMES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pix_en,
   input  logic frame_start,
   input  logic game_over,
   output logic phase
);

   localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic             phase_d, phase_q;

   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (pix_en) begin
         if (!game_over) begin
            cnt_d   = '0;
            phase_d = 1'b1;
         end else if (frame_start) begin
            // Toggling only on frame_start keeps the phase stable across a frame.
            if (cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
               cnt_d   = '0;
               phase_d = ~phase_q;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         phase_q <= 1'b1;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   assign phase = phase_q;

endmodule

// File: rtl/tile_renderer.sv
// Two-stage tile colour pipeline for a snake playfield; optional game-over
// blink enabled with RENDER_BLINK_EN.
`include "infra/defs.vh"

module tile_renderer
   import tile_renderer_pkg::*;
#(
   parameter int CW           = 1,
   parameter int COLS         = `GRID_COLS,
   parameter int ROWS         = `GRID_ROWS,
   parameter int BLINK_FRAMES = 16,
   localparam int AW          = $clog2(COLS * ROWS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pix_en,
   input  logic              de,
   input  logic [GX_W-1:0]   gx,
   input  logic [GY_W-1:0]   gy,
   input  logic              frame_start,
   input  logic [GX_W-1:0]   head_x,
   input  logic [GY_W-1:0]   head_y,
   input  logic [GX_W-1:0]   apple_x,
   input  logic [GY_W-1:0]   apple_y,
   input  logic              game_over,
   output logic [AW-1:0]     map_rd_addr,
   input  logic              map_rd_data,
   output logic [3*CW-1:0]   rgb,
   output logic              de_o
);

   function automatic logic [3*CW-1:0] expand(input logic [2:0] c);
      return {{CW{c[2]}}, {CW{c[1]}}, {CW{c[0]}}};
   endfunction

   logic blink_phase;

`ifdef RENDER_BLINK_EN
   blink_timer #(
      .BLINK_FRAMES (BLINK_FRAMES)
   ) u_blink_timer (
      .clk         (clk),
      .rst_n       (rst_n),
      .pix_en      (pix_en),
      .frame_start (frame_start),
      .game_over   (game_over),
      .phase       (blink_phase)
   );
`else
   logic unused_blink;
   assign blink_phase  = 1'b1;
   assign unused_blink = ^{frame_start, game_over} ^ (BLINK_FRAMES > 0);
`endif

   logic          in_range, border, head_hit, apple_hit;
   logic [AW-1:0] lin_addr;

   logic          de_d, de_q;
   logic          vis_d, vis_q;
   logic          border_d, border_q;
   logic          head_d, head_q;
   logic          apple_d, apple_q;
   logic [AW-1:0] addr_d, addr_q;

   always_comb begin
      in_range  = (int'(gx) < COLS) && (int'(gy) < ROWS);
      border    = (gx == '0) || (int'(gx) == COLS - 1) ||
                  (gy == '0) || (int'(gy) == ROWS - 1);
      head_hit  = (gx == head_x) && (gy == head_y);
      apple_hit = (gx == apple_x) && (gy == apple_y);
      lin_addr  = AW'(gy) * AW'(COLS) + AW'(gx);

      de_d     = de_q;
      vis_d    = vis_q;
      border_d = border_q;
      head_d   = head_q;
      apple_d  = apple_q;
      addr_d   = addr_q;
      if (pix_en) begin
         de_d     = de;
         // Off-grid beam positions render black and must not index the map.
         vis_d    = de && in_range;
         border_d = in_range && border;
         head_d   = in_range && head_hit;
         apple_d  = in_range && apple_hit;
         addr_d   = in_range ? lin_addr : '0;
      end
   end

   pal_sel_t        sel;
   logic [3*CW-1:0] rgb_d, rgb_q;
   logic            de_o_d, de_o_q;

   always_comb begin
      sel = PAL_BLK;
      if (!vis_q)
         sel = PAL_BLK;
      else if (border_q)
         sel = PAL_EDGE;
      else if (head_q)
         sel = blink_phase ? PAL_HEAD : PAL_BG;
      else if (apple_q)
         sel = PAL_APPLE;
      else if (map_rd_data)
         sel = blink_phase ? PAL_BODY : PAL_BG;
      else
         sel = PAL_BG;

      rgb_d  = rgb_q;
      de_o_d = de_o_q;
      if (pix_en) begin
         rgb_d  = expand(pal_rgb(sel));
         de_o_d = de_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         de_q     <= 1'b0;
         vis_q    <= 1'b0;
         border_q <= 1'b0;
         head_q   <= 1'b0;
         apple_q  <= 1'b0;
         addr_q   <= '0;
         rgb_q    <= '0;
         de_o_q   <= 1'b0;
      end else begin
         de_q     <= de_d;
         vis_q    <= vis_d;
         border_q <= border_d;
         head_q   <= head_d;
         apple_q  <= apple_d;
         addr_q   <= addr_d;
         rgb_q    <= rgb_d;
         de_o_q   <= de_o_d;
      end
   end

   assign map_rd_addr = addr_q;
   assign rgb         = rgb_q;
   assign de_o        = de_o_q;

endmodule

// File: tb/tb_tile_renderer.sv
// Directed bench for tile_renderer with CW=4, 160x120 grid, BLINK_FRAMES=2.
module tb_tile_renderer;

   localparam int CW = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pix_en;
   logic        de;
   logic [7:0]  gx;
   logic [6:0]  gy;
   logic        frame_start;
   logic [7:0]  head_x, apple_x;
   logic [6:0]  head_y, apple_y;
   logic        game_over;
   logic [14:0] map_rd_addr;
   logic        map_rd_data;
   logic [11:0] rgb;
   logic        de_o;

   int vectors     = 0;
   int miscompares = 0;

   localparam logic [11:0] C_BLK   = 12'h000;
   localparam logic [11:0] C_BG    = 12'h00F;
   localparam logic [11:0] C_EDGE  = 12'hFFF;
   localparam logic [11:0] C_HEAD  = 12'hFF0;
   localparam logic [11:0] C_APPLE = 12'hF00;
   localparam logic [11:0] C_BODY  = 12'h0F0;

   always #5 clk = ~clk;

   tile_renderer #(
      .CW           (CW),
      .COLS         (160),
      .ROWS         (120),
      .BLINK_FRAMES (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pix_en      (pix_en),
      .de          (de),
      .gx          (gx),
      .gy          (gy),
      .frame_start (frame_start),
      .head_x      (head_x),
      .head_y      (head_y),
      .apple_x     (apple_x),
      .apple_y     (apple_y),
      .game_over   (game_over),
      .map_rd_addr (map_rd_addr),
      .map_rd_data (map_rd_data),
      .rgb         (rgb),
      .de_o        (de_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One pixel through the pipeline: map data is returned after the address beat.
   task automatic render(input logic [7:0] x, input logic [6:0] y, input logic v,
                         input logic d, input logic [11:0] exp, input string tag);
      de = v; gx = x; gy = y;
      tick();
      map_rd_data = d;
      tick();
      chk(tag, rgb, exp);
      chk({tag, "_de"}, de_o, v);
   endtask

   task automatic pulse_frame();
      de = 1'b0; frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   logic [7:0] vis_exp;

   initial begin
      rst_n = 1'b0; pix_en = 1'b1; de = 1'b0; gx = '0; gy = '0;
      frame_start = 1'b0; game_over = 1'b0; map_rd_data = 1'b0;
      head_x = 8'd10; head_y = 7'd10; apple_x = 8'd30; apple_y = 7'd30;

      #3;
      chk("rst_rgb", rgb, 0);
      chk("rst_de_o", de_o, 0);
      chk("rst_addr", map_rd_addr, 0);

      @(negedge clk); rst_n = 1'b1;
      #1;

      // Left border, exact two-beat latency.
      de = 1'b1; gx = 8'd0; gy = 7'd5;
      tick();
      chk("edge_lat1_de", de_o, 0);
      tick();
      chk("edge_rgb", rgb, C_EDGE);
      chk("edge_de", de_o, 1);

      // Head and apple on the same occupied cell.
      apple_x = 8'd10; apple_y = 7'd10;
      render(8'd10, 7'd10, 1'b1, 1'b1, C_HEAD, "head_apple");
      apple_x = 8'd30; apple_y = 7'd30;

      // Address generation and body colour.
      de = 1'b1; gx = 8'd20; gy = 7'd3;
      tick();
      chk("addr_500", map_rd_addr, 500);
      map_rd_data = 1'b1;
      tick();
      chk("body_rgb", rgb, C_BODY);

      de = 1'b1; gx = 8'd30; gy = 7'd30;
      tick();
      chk("addr_4830", map_rd_addr, 4830);
      map_rd_data = 1'b0;
      tick();
      chk("apple_rgb", rgb, C_APPLE);

      render(8'd50,  7'd40,  1'b1, 1'b0, C_BG,   "bg");
      render(8'd159, 7'd50,  1'b1, 1'b0, C_EDGE, "edge_right");
      render(8'd5,   7'd119, 1'b1, 1'b0, C_EDGE, "edge_bottom");
      render(8'd5,   7'd0,   1'b1, 1'b1, C_EDGE, "edge_top");
      render(8'd50,  7'd40,  1'b0, 1'b1, C_BLK,  "de_low");

      de = 1'b1; gx = 8'd200; gy = 7'd10;
      tick();
      chk("oob_x_addr", map_rd_addr, 0);
      map_rd_data = 1'b1;
      tick();
      chk("oob_x_rgb", rgb, C_BLK);
      chk("oob_x_de", de_o, 1);
      render(8'd5, 7'd120, 1'b1, 1'b1, C_BLK, "oob_y");

      // Head moved mid-frame lands on the very next pixel.
      head_x = 8'd50; head_y = 7'd40;
      render(8'd50, 7'd40, 1'b1, 1'b0, C_HEAD, "head_move");
      head_x = 8'd10; head_y = 7'd10;

      // pix_en alternating: outputs hold on idle beats, latency stays two beats.
      render(8'd50, 7'd40, 1'b1, 1'b0, C_BG, "pre_stall");
      de = 1'b1; gx = 8'd0; gy = 7'd5; pix_en = 1'b1;
      tick();
      pix_en = 1'b0;
      de = 1'b0; gx = 8'd60; gy = 7'd60;
      tick();
      chk("stall1_rgb", rgb, C_BG);
      chk("stall1_addr", map_rd_addr, 5 * 160);
      pix_en = 1'b1;
      de = 1'b1; gx = 8'd20; gy = 7'd3;
      tick();
      chk("stall_beat2_rgb", rgb, C_EDGE);
      pix_en = 1'b0;
      tick();
      chk("stall2_rgb", rgb, C_EDGE);
      chk("stall2_addr", map_rd_addr, 500);
      map_rd_data = 1'b1;
      pix_en = 1'b1;
      tick();
      chk("stall_body_rgb", rgb, C_BODY);
      chk("stall_body_de", de_o, 1);

      // Asynchronous reset in the middle of a line.
      render(8'd0, 7'd5, 1'b1, 1'b0, C_EDGE, "pre_reset");
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("midrst_rgb", rgb, 0);
      chk("midrst_de", de_o, 0);
      chk("midrst_addr", map_rd_addr, 0);
      de = 1'b1; gx = 8'd50; gy = 7'd40; map_rd_data = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      tick();
      chk("rel_beat1_rgb", rgb, 0);
      chk("rel_beat1_de", de_o, 0);
      tick();
      chk("rel_beat2_rgb", rgb, C_BG);
      chk("rel_beat2_de", de_o, 1);

      // Game-over blink over eight frames; game_over drops during frame 6.
`ifdef RENDER_BLINK_EN
      vis_exp = 8'hB3;
`else
      vis_exp = 8'hFF;
`endif
      for (int f = 0; f < 8; f++) begin
         pulse_frame();
         if (f == 0) game_over = 1'b1;
         render(8'd20, 7'd3, 1'b1, 1'b1, vis_exp[f] ? C_BODY : C_BG,
                $sformatf("blink_body_f%0d", f));
         render(8'd10, 7'd10, 1'b1, 1'b0, vis_exp[f] ? C_HEAD : C_BG,
                $sformatf("blink_head_f%0d", f));
         render(8'd30, 7'd30, 1'b1, 1'b0, C_APPLE, $sformatf("blink_apple_f%0d", f));
         render(8'd0, 7'd30, 1'b1, 1'b1, C_EDGE, $sformatf("blink_edge_f%0d", f));
         if (f == 6) game_over = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
